// File: rtl/vga_timing_pkg.sv
// 640x480@60 timing constants shared by the VGA generator and the receive-side decoder,
// plus the lock state machine encoding.
package vga_timing_pkg;

    localparam int H_TOTAL     = 800;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int H_ACTIVE    = 640;
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int V_ACTIVE    = 480;
    localparam int LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } sync_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Holds the previous sync sample and flags a falling edge on the pixel strobe.
// The previous-sample register idles high so a stream starting in sync is seen as an edge.
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pix_en,
    input  logic sync_in,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b1;
        end else if (pix_en) begin
            prev <= sync_in;
        end
    end

    assign fall = pix_en & prev & ~sync_in;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an hsync/vsync/RGB stream, checks line and frame
// lengths, tracks timing lock and captures one probe pixel per frame.
module vga_sync_decoder #(
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BP        = vga_timing_pkg::H_BP,
    parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BP        = vga_timing_pkg::V_BP,
    parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    input  logic [9:0]  probe_h,
    input  logic [9:0]  probe_v,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic [11:0] probe_pixel,
    output logic        probe_done
);
    import vga_timing_pkg::*;

    localparam int HW      = $clog2(2 * H_TOTAL + 1);
    localparam int VW      = $clog2(2 * V_TOTAL + 1);
    localparam int GW      = $clog2(LOCK_FRAMES + 1);
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    logic          h_fall, v_fall;
    sync_state_e   state;
    logic [HW-1:0] hx, hx_new;
    logic [VW-1:0] vy, vy_new;
    logic [GW-1:0] good_frames;
    logic          v_pend;
    logic [9:0]    probe_h_lat, probe_v_lat;
    logic          frame_start, checking, line_bad, frame_bad, any_err;
    logic          in_active, probe_hit;
    logic [9:0]    h_rel, v_rel;

    vga_sync_edge u_hsync_edge (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .sync_in (hsync_in),
        .fall    (h_fall)
    );

    vga_sync_edge u_vsync_edge (
        .clk     (clk),
        .rst     (rst),
        .pix_en  (pix_en),
        .sync_in (vsync_in),
        .fall    (v_fall)
    );

    // Next sample/line index and the length checks they imply; counters saturate instead of wrapping.
    always_comb begin
        frame_start = h_fall & (v_fall | v_pend);
        checking    = (state != ST_SEARCH);
        hx_new      = hx;
        vy_new      = vy;
        line_bad    = 1'b0;
        frame_bad   = 1'b0;
        if (h_fall) begin
            hx_new   = '0;
            line_bad = checking && (hx != HW'(H_TOTAL - 1));
        end else if (pix_en && (hx != HW'(2 * H_TOTAL))) begin
            hx_new   = hx + HW'(1);
            line_bad = checking && (hx == HW'(2 * H_TOTAL - 1));
        end
        if (frame_start) begin
            vy_new    = '0;
            frame_bad = checking && (vy != VW'(V_TOTAL - 1));
        end else if (h_fall && (vy != VW'(2 * V_TOTAL))) begin
            vy_new    = vy + VW'(1);
            frame_bad = checking && (vy == VW'(2 * V_TOTAL - 1));
        end
        any_err   = line_bad | frame_bad;
        in_active = (hx_new >= HW'(H_START)) && (hx_new < HW'(H_START + H_ACTIVE)) &&
                    (vy_new >= VW'(V_START)) && (vy_new < VW'(V_START + V_ACTIVE));
        h_rel     = 10'(hx_new - HW'(H_START));
        v_rel     = 10'(vy_new - VW'(V_START));
        probe_hit = (state == ST_LOCKED) && in_active && !any_err &&
                    (h_rel == probe_h_lat) && (v_rel == probe_v_lat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SEARCH;
            good_frames <= '0;
            hx          <= '0;
            vy          <= '0;
            v_pend      <= 1'b0;
            probe_h_lat <= '0;
            probe_v_lat <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            probe_pixel <= '0;
            probe_done  <= 1'b0;
        end else begin
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            probe_done <= 1'b0;
            if (pix_en) begin
                hx <= hx_new;
                vy <= vy_new;
                if (frame_start) begin
                    v_pend      <= 1'b0;
                    probe_h_lat <= probe_h;
                    probe_v_lat <= probe_v;
                end else if (v_fall) begin
                    v_pend <= 1'b1;
                end
                h_cnt     <= in_active ? h_rel : 10'd0;
                v_cnt     <= in_active ? v_rel : 10'd0;
                valid     <= in_active && (state == ST_LOCKED);
                line_err  <= line_bad;
                frame_err <= frame_bad;
                if (probe_hit) begin
                    probe_pixel <= rgb_in;
                    probe_done  <= 1'b1;
                end
                if (any_err) begin
                    state       <= ST_SEARCH;
                    good_frames <= '0;
                    locked      <= 1'b0;
                end else begin
                    case (state)
                        ST_SEARCH: if (frame_start) state <= ST_MEASURE;
                        ST_MEASURE: begin
                            if (frame_start) begin
                                if (good_frames == GW'(LOCK_FRAMES - 1)) begin
                                    state       <= ST_LOCKED;
                                    locked      <= 1'b1;
                                    good_frames <= '0;
                                end else begin
                                    good_frames <= good_frames + GW'(1);
                                end
                            end
                        end
                        ST_LOCKED: ;
                        default: state <= ST_SEARCH;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down raster so whole frames stay short.
module tb_vga_sync_decoder;

    localparam int HT = 20, HS = 3, HB = 2, HA = 12;
    localparam int VT = 12, VS = 2, VB = 2, VA = 6;
    localparam int LF = 2;
    localparam int HST = HS + HB;
    localparam int VST = VS + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [11:0] rgb_in = '0;
    logic [9:0]  probe_h = '0;
    logic [9:0]  probe_v = '0;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid, locked, line_err, frame_err, probe_done;
    logic [11:0] probe_pixel;

    int n_vec = 0, n_mis = 0;
    int n_valid = 0, n_le = 0, n_fe = 0, n_pd = 0;
    int lock_start, le_lock;
    int s_h0, s_v0, s_val0, s_hl, s_vl, s_valx;
    int f_valid, f_le, f_fe, f_pd;
    int probe_x = 0, probe_y = 0;
    logic [11:0] probe_rgb = 12'h000;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .rgb_in      (rgb_in),
        .probe_h     (probe_h),
        .probe_v     (probe_v),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .valid       (valid),
        .locked      (locked),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .probe_pixel (probe_pixel),
        .probe_done  (probe_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (line_err)   n_le++;
        if (frame_err)  n_fe++;
        if (probe_done) n_pd++;
    end

    initial begin
        #900_000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel strobe followed by one idle clock.
    task automatic put(input logic hs, input logic vs, input logic [11:0] rgb);
        hsync_in = hs;
        vsync_in = vs;
        rgb_in   = rgb;
        pix_en   = 1'b1;
        @(posedge clk); #1;
        pix_en = 1'b0;
        if (valid) n_valid++;
        if (line_err) le_lock = int'(locked);
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int nlines, input int short_l, input int abort_at);
        int v0, le0, fe0, pd0, idx, len;
        logic hs, vs;
        logic [11:0] rgb;
        v0 = n_valid; le0 = n_le; fe0 = n_fe; pd0 = n_pd;
        idx = 0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_l) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                if (abort_at >= 0 && idx == abort_at) return;
                hs  = (x < HS) ? 1'b0 : 1'b1;
                vs  = (l < VS) ? 1'b0 : 1'b1;
                rgb = (x == HST + probe_x && l == VST + probe_y) ? probe_rgb
                                                                 : {4'(x), 4'(l), 4'h5};
                put(hs, vs, rgb);
                if (idx == 0) lock_start = int'(locked);
                if (l == VST && x == HST) begin
                    s_h0 = int'(h_cnt); s_v0 = int'(v_cnt); s_val0 = int'(valid);
                end
                if (l == VST + VA - 1 && x == HST + HA - 1) begin
                    s_hl = int'(h_cnt); s_vl = int'(v_cnt);
                end
                if (l == VST && x == HST + HA) s_valx = int'(valid);
                idx++;
            end
        end
        f_valid = n_valid - v0;
        f_le    = n_le - le0;
        f_fe    = n_fe - fe0;
        f_pd    = n_pd - pd0;
    endtask

    task automatic set_probe(input int px, input int py, input logic [11:0] color);
        probe_x   = px;
        probe_y   = py;
        probe_h   = 10'(px);
        probe_v   = 10'(py);
        probe_rgb = color;
    endtask

    initial begin
        int le0, wrap_seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coord", {12'h0, h_cnt, v_cnt}, 32'h0);
        chk("rst_flags", {27'h0, valid, locked, line_err, frame_err, probe_done}, 32'h0);
        chk("rst_probe_pixel", {20'h0, probe_pixel}, 32'h0);
        rst = 1'b0;

        set_probe(4, 3, 12'h888);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        chk("f2_lock_start", lock_start, 0);
        chk("f2_valid_count", f_valid, 0);
        send_frame(VT, -1, -1);
        chk("f3_lock_start", lock_start, 1);
        chk("f3_valid_count", f_valid, HA * VA);
        chk("f3_first_h", s_h0, 0);
        chk("f3_first_v", s_v0, 0);
        chk("f3_first_valid", s_val0, 1);
        chk("f3_last_h", s_hl, HA - 1);
        chk("f3_last_v", s_vl, VA - 1);
        chk("f3_after_line_valid", s_valx, 0);
        chk("f3_probe_done_count", f_pd, 1);
        chk("f3_probe_pixel", {20'h0, probe_pixel}, 32'h888);
        chk("f3_err_pulses", f_le + f_fe, 0);

        // Sync inputs toggle while the strobe is idle; nothing may be detected.
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        le0 = n_le;
        repeat (6) @(posedge clk);
        #1;
        chk("idle_locked", {31'h0, locked}, 32'h1);
        chk("idle_pulses", n_le - le0, 0);

        set_probe(20, 1, 12'h777);
        send_frame(VT, -1, -1);
        chk("f4_lock_start", lock_start, 1);
        chk("f4_frame_err", f_fe, 0);
        chk("f4_probe_outside", f_pd, 0);
        chk("f4_probe_pixel_held", {20'h0, probe_pixel}, 32'h888);

        le_lock = 1;
        send_frame(VT, 5, -1);
        chk("f5_line_err_count", f_le, 1);
        chk("f5_locked_at_err", le_lock, 0);
        chk("f5_frame_err", f_fe, 0);
        send_frame(VT, -1, -1);
        chk("f6_lock_start", lock_start, 0);
        send_frame(VT, -1, -1);
        chk("f7_lock_start", lock_start, 0);
        send_frame(VT - 1, -1, -1);
        chk("f8_lock_start", lock_start, 1);
        send_frame(VT, -1, -1);
        chk("f9_lock_start", lock_start, 0);
        chk("f9_frame_err_count", f_fe, 1);
        chk("f9_line_err", f_le, 0);
        chk("f9_valid_count", f_valid, 0);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        chk("f11_lock_start", lock_start, 0);
        set_probe(4, 3, 12'hA5C);
        send_frame(VT, -1, -1);
        chk("f12_lock_start", lock_start, 1);
        chk("f12_valid_count", f_valid, HA * VA);
        chk("f12_probe_done_count", f_pd, 1);
        chk("f12_probe_pixel", {20'h0, probe_pixel}, 32'hA5C);

        send_frame(VT, -1, (VST + 2) * HT + HST + 3);
        chk("pre_rst_valid", {31'h0, valid}, 32'h1);
        chk("pre_rst_locked", {31'h0, locked}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_coord", {12'h0, h_cnt, v_cnt}, 32'h0);
        chk("mid_rst_flags", {27'h0, valid, locked, line_err, frame_err, probe_done}, 32'h0);
        chk("mid_rst_probe_pixel", {20'h0, probe_pixel}, 32'h0);
        send_frame(VT, -1, -1);
        send_frame(VT, -1, -1);
        chk("f15_lock_start", lock_start, 0);
        send_frame(VT, -1, -1);
        chk("f16_lock_start", lock_start, 1);

        send_frame(VT, -1, 4 * HT);
        le0 = n_le;
        wrap_seen = 0;
        for (int k = 0; k < 100; k++) begin
            put(1'b0, 1'b1, 12'h0F0);
            if (k >= 2 * HT && h_cnt != 10'd0) wrap_seen = 1;
        end
        chk("hold_line_err_count", n_le - le0, 1);
        chk("hold_no_wrap", wrap_seen, 0);
        chk("hold_locked", {31'h0, locked}, 32'h0);
        chk("hold_h_cnt", {22'h0, h_cnt}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
